// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel with shadowed divisor.
// Counts system cycles, toggles clk_out_o and strobes tick_o at each wrap.
module clk_div_chan #(
  parameter int WIDTH       = 32,
  parameter int DEFAULT_DIV = 50
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             sync_restart_i,
  input  logic             cfg_load_i,
  input  logic [WIDTH-1:0] div_cfg_i,
  output logic             clk_out_o,
  output logic             tick_o,
  output logic             cfg_pending_o
);

  localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] last_cnt;
  logic             wrap;

  // terminal count; an active divisor of 0 behaves as 1
  always_comb begin
    last_cnt = (active_q == '0) ? '0 : active_q - WIDTH'(1);
    wrap     = (cnt_q == last_cnt);
  end

  // next state: restart > disable > wrap/count, load on shadow last
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    clk_d    = clk_q;
    tick_d   = tick_q;
    if (sync_restart_i || !en_i) begin
      cnt_d  = '0;
      clk_d  = 1'b0;
      tick_d = 1'b0;
      if (pend_q) begin
        active_d = shadow_q;
        pend_d   = 1'b0;
      end
    end else if (wrap) begin
      cnt_d  = '0;
      clk_d  = ~clk_q;
      tick_d = 1'b1;
      if (pend_q) begin
        active_d = shadow_q;
        pend_d   = 1'b0;
      end
    end else begin
      cnt_d  = cnt_q + WIDTH'(1);
      tick_d = 1'b0;
    end
    if (cfg_load_i) begin
      shadow_d = div_cfg_i;
      pend_d   = 1'b1;
    end
  end

  // channel state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      active_q <= DEF;
      shadow_q <= DEF;
      pend_q   <= 1'b0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
    end
  end

  assign clk_out_o     = clk_q;
  assign tick_o        = tick_q;
  assign cfg_pending_o = pend_q;

endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: NUM_CH independent shadowed clock dividers.
// Slices div_cfg per channel and fans out load/restart strobes.
module clk_div_multi #(
  parameter int NUM_CH      = 2,
  parameter int WIDTH       = 32,
  parameter int DEFAULT_DIV = 50
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       en,
  input  logic                    sync_restart,
  input  logic                    cfg_load,
  input  logic [NUM_CH*WIDTH-1:0] div_cfg,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       cfg_pending
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_chan #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk            (clk),
      .rst_n          (rst_n),
      .en_i           (en[i]),
      .sync_restart_i (sync_restart),
      .cfg_load_i     (cfg_load),
      .div_cfg_i      (div_cfg[i*WIDTH +: WIDTH]),
      .clk_out_o      (clk_out[i]),
      .tick_o         (tick[i]),
      .cfg_pending_o  (cfg_pending[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: scoreboard bench for clk_div_multi.
// Expected tick edges are queued per channel and matched by a monitor.
module tb_clk_div_multi;

  localparam int NCH = 2;
  localparam int W   = 8;

  logic           clk;
  logic           rst_n;
  logic [NCH-1:0] en;
  logic           sync_restart;
  logic           cfg_load;
  logic [NCH*W-1:0] div_cfg;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] cfg_pending;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mon_from = 1000000;
  int mon_to = -1;
  int q0[$];
  int q1[$];

  clk_div_multi #(
    .NUM_CH      (NCH),
    .WIDTH       (W),
    .DEFAULT_DIV (50)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .sync_restart (sync_restart),
    .cfg_load     (cfg_load),
    .div_cfg      (div_cfg),
    .clk_out      (clk_out),
    .tick         (tick),
    .cfg_pending  (cfg_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: pop expected tick edges as ticks appear
  always @(negedge clk) begin
    if (cyc >= mon_from && cyc <= mon_to) begin
      if (tick[0]) begin
        checks++;
        if (q0.size() == 0 || q0[0] != cyc) begin
          errors++;
          $display("FAIL tick0 unexpected at edge %0d (next expected %0d)",
                   cyc, (q0.size() != 0) ? q0[0] : -1);
        end else void'(q0.pop_front());
      end else if (q0.size() != 0 && q0[0] <= cyc) begin
        checks++;
        errors++;
        $display("FAIL tick0 missing: got 0 at edge %0d, required 1 at %0d", cyc, q0[0]);
        void'(q0.pop_front());
      end
      if (tick[1]) begin
        checks++;
        if (q1.size() == 0 || q1[0] != cyc) begin
          errors++;
          $display("FAIL tick1 unexpected at edge %0d (next expected %0d)",
                   cyc, (q1.size() != 0) ? q1[0] : -1);
        end else void'(q1.pop_front());
      end else if (q1.size() != 0 && q1[0] <= cyc) begin
        checks++;
        errors++;
        $display("FAIL tick1 missing: got 0 at edge %0d, required 1 at %0d", cyc, q1[0]);
        void'(q1.pop_front());
      end
    end
  end

  task automatic wait_to(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic load_and_restart(input logic [NCH*W-1:0] cfg, input int k);
    cfg_load = 1'b1;
    div_cfg  = cfg;
    wait_to(k + 1);
    cfg_load     = 1'b0;
    sync_restart = 1'b1;
    wait_to(k + 2);
    sync_restart = 1'b0;
  endtask

  task automatic test_reset(output int base);
    rst_n = 1'b0;
    en = '0;
    sync_restart = 1'b0;
    cfg_load = 1'b0;
    div_cfg = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({clk_out, tick, cfg_pending} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outs got %b required 000000", {clk_out, tick, cfg_pending});
    end
    en = 2'b11;
    base = cyc;
    mon_from = base + 1;
    mon_to = base + 100;
    q0.push_back(base + 50); q0.push_back(base + 100);
    q1.push_back(base + 50); q1.push_back(base + 100);
    rst_n = 1'b1;
    wait_to(base + 49);
    checks++;
    if (clk_out !== 2'b00) begin
      errors++; $display("FAIL rst_clk49 got %b required 00", clk_out);
    end
    wait_to(base + 50);
    checks++;
    if (clk_out !== 2'b11) begin
      errors++; $display("FAIL rst_clk50 got %b required 11", clk_out);
    end
    wait_to(base + 100);
    checks++;
    if (clk_out !== 2'b00 || cfg_pending !== 2'b00) begin
      errors++;
      $display("FAIL rst_clk100 got clk %b pend %b required 00 00", clk_out, cfg_pending);
    end
    wait_to(base + 101);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++; $display("FAIL rst_queue left %0d/%0d required 0/0", q0.size(), q1.size());
    end
  endtask

  task automatic test_shadow_update(input int base);
    mon_from = base + 101;
    mon_to = base + 180;
    for (int t = 150; t <= 180; t += 3) q0.push_back(base + t);
    for (int t = 150; t <= 180; t += 6) q1.push_back(base + t);
    wait_to(base + 120);
    cfg_load = 1'b1;
    div_cfg = {8'd6, 8'd3};
    wait_to(base + 121);
    cfg_load = 1'b0;
    checks++;
    if (cfg_pending !== 2'b11) begin
      errors++; $display("FAIL shd_pend got %b required 11", cfg_pending);
    end
    wait_to(base + 149);
    checks++;
    if (cfg_pending !== 2'b11) begin
      errors++; $display("FAIL shd_pend149 got %b required 11", cfg_pending);
    end
    wait_to(base + 150);
    checks++;
    if (cfg_pending !== 2'b00 || clk_out !== 2'b11) begin
      errors++;
      $display("FAIL shd_wrap got pend %b clk %b required 00 11", cfg_pending, clk_out);
    end
    wait_to(base + 153);
    checks++;
    if (clk_out !== 2'b10) begin
      errors++; $display("FAIL shd_clk153 got %b required 10", clk_out);
    end
    wait_to(base + 181);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++; $display("FAIL shd_queue left %0d/%0d required 0/0", q0.size(), q1.size());
    end
  endtask

  task automatic test_degenerate();
    int k;
    k = cyc;
    mon_from = k + 3;
    mon_to = k + 12;
    for (int t = 3; t <= 12; t++) begin
      q0.push_back(k + t);
      q1.push_back(k + t);
    end
    load_and_restart({8'd0, 8'd1}, k);
    checks++;
    if ({clk_out, tick, cfg_pending} !== 6'b0) begin
      errors++;
      $display("FAIL deg_restart got %b required 000000", {clk_out, tick, cfg_pending});
    end
    for (int j = 3; j <= 12; j++) begin
      wait_to(k + j);
      checks++;
      if (clk_out !== ((j % 2 == 1) ? 2'b11 : 2'b00) || tick !== 2'b11) begin
        errors++;
        $display("FAIL deg_cycle%0d got clk %b tick %b", j, clk_out, tick);
      end
    end
    wait_to(k + 13);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++; $display("FAIL deg_queue left %0d/%0d required 0/0", q0.size(), q1.size());
    end
  endtask

  task automatic test_enable_drop();
    int k;
    k = cyc;
    mon_from = k + 3;
    mon_to = k + 45;
    q0.push_back(k + 12); q0.push_back(k + 29); q0.push_back(k + 39);
    for (int t = 9; t <= 45; t += 7) q1.push_back(k + t);
    load_and_restart({8'd7, 8'd10}, k);
    wait_to(k + 16);
    checks++;
    if (clk_out[0] !== 1'b1) begin
      errors++; $display("FAIL en_pre got %b required 1", clk_out[0]);
    end
    en = 2'b10;
    wait_to(k + 17);
    checks++;
    if (clk_out[0] !== 1'b0 || tick[0] !== 1'b0) begin
      errors++;
      $display("FAIL en_drop got clk %b tick %b required 0 0", clk_out[0], tick[0]);
    end
    wait_to(k + 19);
    en = 2'b11;
    wait_to(k + 28);
    checks++;
    if (tick[0] !== 1'b0) begin
      errors++; $display("FAIL en_early got %b required 0", tick[0]);
    end
    wait_to(k + 46);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++; $display("FAIL en_queue left %0d/%0d required 0/0", q0.size(), q1.size());
    end
  endtask

  task automatic test_alignment();
    int k;
    k = cyc;
    mon_from = k + 3;
    mon_to = k + 38;
    for (int t = 6; t <= 38; t += 4) q0.push_back(k + t);
    for (int t = 8; t <= 38; t += 6) q1.push_back(k + t);
    load_and_restart({8'd6, 8'd4}, k);
    checks++;
    if (clk_out !== 2'b00) begin
      errors++; $display("FAIL aln_restart got %b required 00", clk_out);
    end
    for (int t = 14; t <= 38; t += 12) begin
      wait_to(k + t);
      checks++;
      if (tick !== 2'b11) begin
        errors++; $display("FAIL aln_coincide%0d got %b required 11", t, tick);
      end
    end
    wait_to(k + 39);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++; $display("FAIL aln_queue left %0d/%0d required 0/0", q0.size(), q1.size());
    end
  endtask

  task automatic test_reset_midop();
    int n;
    int c;
    n = 0;
    while (clk_out[0] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (clk_out[0] !== 1'b1) begin
      errors++; $display("FAIL mid_find got %b required 1 within 20 cycles", clk_out[0]);
    end
    cfg_load = 1'b1;
    div_cfg = {8'd9, 8'd9};
    @(negedge clk);
    cfg_load = 1'b0;
    checks++;
    if (clk_out[0] !== 1'b1 || cfg_pending !== 2'b11) begin
      errors++;
      $display("FAIL mid_pre got clk %b pend %b required 1 11", clk_out[0], cfg_pending);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({clk_out, tick, cfg_pending} !== 6'b0) begin
      errors++;
      $display("FAIL mid_async got %b required 000000", {clk_out, tick, cfg_pending});
    end
    @(negedge clk);
    c = cyc;
    mon_from = c + 1;
    mon_to = c + 101;
    q0.push_back(c + 50); q0.push_back(c + 100);
    q1.push_back(c + 50); q1.push_back(c + 100);
    rst_n = 1'b1;
    wait_to(c + 1);
    checks++;
    if (cfg_pending !== 2'b00) begin
      errors++; $display("FAIL mid_pend got %b required 00", cfg_pending);
    end
    wait_to(c + 50);
    checks++;
    if (clk_out !== 2'b11) begin
      errors++; $display("FAIL mid_clk50 got %b required 11", clk_out);
    end
    wait_to(c + 102);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++; $display("FAIL mid_queue left %0d/%0d required 0/0", q0.size(), q1.size());
    end
  endtask

  initial begin
    int base;
    test_reset(base);
    test_shadow_update(base);
    test_degenerate();
    test_enable_drop();
    test_alignment();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
